// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage sequencer for a 16-bit asynchronous SRAM.
// Each 32-bit load/store is split into a low and a high halfword phase, and each
// phase lasts WAIT_CYCLES cycles. The ready output is low while an access is in
// flight, so the pipeline freeze logic can hold the pipeline registers.
// Optional feature: define SRAM_CTRL_LAST_READ_HIT_EN to enable the last-read hit
// path. With it, a load that repeats the word of the last completed load finishes
// in a single cycle.
module mem_stage_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int unsigned    CntW    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [15:0]         wdata_hi_q, wdata_hi_d;
    logic [15:0]         hold_q, hold_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                oe_q, oe_d;
    logic                we_n_q, we_n_d;

    logic                req;
    logic                phase_last;
    logic [31:0]         offset;
    logic [SRAM_AW-2:0]  word_idx;
    logic                unused_offset_bits;

    assign req        = rd_en | wr_en;
    assign phase_last = (cnt_q == CntLast);
    // The offset wraps modulo 2^32. Only the SRAM word index bits are used.
    assign offset     = address - BASE_ADDR;
    assign word_idx   = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

`ifdef SRAM_CTRL_LAST_READ_HIT_EN
    logic [31:0] addr_q, addr_d;
    logic [31:0] tag_q, tag_d;
    logic        valid_q, valid_d;
    logic        hit;
    logic        unused_tag_bits;

    // Both enables high means a write, so a hit needs a pure read.
    assign hit             = rd_en & ~wr_en & valid_q & (address[31:2] == tag_q[31:2]);
    assign unused_tag_bits = ^tag_q[1:0];
`endif

    // The pipeline may advance when no request is pending or when the access completes.
    always_comb begin
        ready = ((state_q == StIdle) && !req) || (state_q == StDone);
    end

    // Next-state logic and registered SRAM bus values. Bus values only change on phase entry.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        wdata_hi_d  = wdata_hi_q;
        hold_d      = hold_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        oe_d        = oe_q;
        we_n_d      = we_n_q;
`ifdef SRAM_CTRL_LAST_READ_HIT_EN
        addr_d      = addr_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req) begin
`ifdef SRAM_CTRL_LAST_READ_HIT_EN
                    if (hit) begin
                        state_d = StDone;
                    end else begin
                        addr_d = address;
                        if (wr_en) begin
                            valid_d = 1'b0;
                        end
`endif
                        state_d     = StLow;
                        cnt_d       = '0;
                        op_wr_d     = wr_en;
                        wdata_hi_d  = wdata[31:16];
                        sram_addr_d = {word_idx, 1'b0};
                        dq_out_d    = wdata[15:0];
                        oe_d        = wr_en;
                        we_n_d      = ~wr_en;
`ifdef SRAM_CTRL_LAST_READ_HIT_EN
                    end
`endif
                end
            end
            StLow: begin
                if (phase_last) begin
                    state_d        = StHigh;
                    cnt_d          = '0;
                    sram_addr_d[0] = 1'b1;
                    dq_out_d       = wdata_hi_q;
                    if (!op_wr_q) begin
                        hold_d = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHigh: begin
                if (phase_last) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                    we_n_d  = 1'b1;
                    if (!op_wr_q) begin
                        rdata_d = {sram_dq_in, hold_q};
`ifdef SRAM_CTRL_LAST_READ_HIT_EN
                        tag_d   = addr_q;
                        valid_d = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and bus registers with a synchronous reset. A reset mid-access discards the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            wdata_hi_q  <= '0;
            hold_q      <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
`ifdef SRAM_CTRL_LAST_READ_HIT_EN
            addr_q      <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            wdata_hi_q  <= wdata_hi_d;
            hold_q      <= hold_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            oe_q        <= oe_d;
            we_n_q      <= we_n_d;
`ifdef SRAM_CTRL_LAST_READ_HIT_EN
            addr_q      <= addr_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
`endif
        end
    end

    assign rdata       = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Sequencer for the MEM stage of the pipelined ARM core. It turns the memory read and write enables, the ALU result address and the Val_Rm store data held in the EXE/MEM pipeline register into multi-cycle accesses on an external 16-bit asynchronous SRAM. Each 32-bit word takes two halfword phases. While an access is in flight, `ready` stays low, and the hazard/freeze logic uses it to hold every pipeline register.

## Interface
- `WAIT_CYCLES`, 2: cycles each halfword phase is held on the SRAM bus; must be ≥1.
- `BASE_ADDR`, 1024: byte address that maps to SRAM halfword 0.
- `SRAM_AW`, 18: SRAM halfword address width.
- `clk` in 1: the single clock; everything updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_en` in 1: load request from the EXE/MEM register.
- `wr_en` in 1: store request from the EXE/MEM register.
- `address` in 32: byte address (the ALU result); bits [1:0] are ignored.
- `wdata` in 32: store data (Val_Rm).
- `rdata` out 32: last completed load word.
- `ready` out 1: high when the MEM stage may advance; pipeline freeze = `~ready`.
- `sram_addr` out SRAM_AW: SRAM halfword address.
- `sram_dq_out` out 16: write data driven toward the SRAM.
- `sram_dq_oe` out 1: enables the `sram_dq_out` drive.
- `sram_dq_in` in 16: read data returned by the SRAM.
- `sram_we_n` out 1: active-low SRAM write strobe.

## Operation
- **States:**
  - IDLE: no request pending.
  - LOW: lower halfword phase.
  - HIGH: upper halfword phase.
  - DONE: access complete.
- **Transitions:**
  - IDLE → LOW when `rd_en | wr_en` is sampled high.
  - LOW → HIGH after WAIT_CYCLES cycles.
  - HIGH → DONE after WAIT_CYCLES cycles.
  - DONE → IDLE unconditionally.
- **Operation latch:** the operation (read/write), `address` and `wdata` are latched on the IDLE→LOW edge and are not re-sampled until the next IDLE. If `rd_en` and `wr_en` are both high, the request is a write.
- **Address mapping:** offset = `address - BASE_ADDR` (32-bit, wraps modulo 2^32). `sram_addr = {offset[SRAM_AW:2], half}`, where half = 0 in LOW and 1 in HIGH. In IDLE and DONE, `sram_addr` holds its last value.
- **Wait counter:** width ceil(log2(WAIT_CYCLES+1)). It clears on every phase entry and counts 0..WAIT_CYCLES-1; the phase ends when the count equals WAIT_CYCLES-1.
- **Write phases:**
  - `sram_dq_oe`=1 and `sram_we_n`=0 for every cycle of LOW and HIGH.
  - `sram_dq_out` = `wdata[15:0]` in LOW, `wdata[31:16]` in HIGH.
  - In IDLE and DONE: `sram_we_n`=1 and `sram_dq_oe`=0.
- **Read phases:**
  - `sram_we_n`=1 and `sram_dq_oe`=0 throughout.
  - On the last cycle of LOW, `sram_dq_in` is captured into a holding register.
  - On the last cycle of HIGH, `rdata` ← {`sram_dq_in`, holding register}.
  - `rdata` changes only on a completed read.
- **`ready` (combinational):** high when (state==IDLE && !(rd_en|wr_en)) or state==DONE; low otherwise.
- **Reset (`rst`=1), including mid-access:** the next state is IDLE and the counter is 0. Outputs take these values:
  - `rdata`=0
  - `sram_addr`=0
  - `sram_dq_out`=0
  - `sram_dq_oe`=0
  - `sram_we_n`=1
  - `ready` then follows its combinational rule.
- **Aborted access:** an access aborted by reset is discarded. A write may have updated only the low halfword.

## Timing
- The request is first visible in cycle 0, in IDLE, where `ready`=0.
- LOW occupies cycles 1..W and HIGH occupies cycles W+1..2W.
- DONE is cycle 2W+1, with `ready`=1 and `rdata` valid for a read.
- Freeze length is 2W+1 cycles; for W=2, `ready` is low in cycles 0–4 and high in cycle 5.
- Back-to-back requests: the pipeline advances at the end of DONE, and the next request is seen in IDLE one cycle later. There is one IDLE cycle with `ready`=0 between accesses.
- `sram_addr`, `sram_dq_out`, `sram_dq_oe` and `sram_we_n` are registered and stable for the whole phase. They change only on phase boundaries.

## Configuration
- **`SRAM_CTRL_LAST_READ_HIT_EN` defined:**
  - A 32-bit tag register plus a valid bit record the address of the last completed read.
  - A read whose word address equals the tag while valid=1 goes IDLE→DONE directly and leaves `rdata` unchanged. `ready` is low for 1 cycle instead of 2W+1.
  - Any write that enters LOW clears valid.
  - Reset clears valid.
- **Undefined:** no tag logic; every read takes the full 2W+1-cycle sequence.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `rd_en`=`wr_en`=0 → `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `rdata`=0, `sram_addr`=0.
- **Write (W=2):** `wr_en`=1, `address`=1032, `wdata`=0xDEADBEEF →
  - cycles 1–2: `sram_addr`=4, `sram_dq_out`=0xBEEF, `sram_we_n`=0;
  - cycles 3–4: `sram_addr`=5, `sram_dq_out`=0xDEAD;
  - cycle 5: `ready`=1.
- **Read back:** `rd_en`=1, `address`=1032, against an SRAM model holding the data above → `ready` low for cycles 0–4; `rdata`=0xDEADBEEF with `ready`=1 in cycle 5.
- **Simultaneous enables:** `rd_en`=`wr_en`=1, `address`=1024, `wdata`=0x12345678 → write to SRAM halfwords 0 and 1; `rdata` unchanged.
- **Reset mid-access:** `rst` asserted during cycle 3 of a read → next cycle IDLE with `rdata`=0 and `sram_we_n`=1. A fresh read then completes in 5 cycles.
- **Read hit with `SRAM_CTRL_LAST_READ_HIT_EN`:** two consecutive reads of 1032 → second read freezes 1 cycle. After an intervening write to 2000, a third read of 1032 freezes 5 cycles. Without the macro, every read freezes 5 cycles.
